// File: rtl/rails_stack_checker.sv
// Stack-station feasibility checker with back-pressure.
// Reports achievability of a departure order and first failing position.
module rails_stack_checker #(
  parameter int DATA_W = 4,
  parameter int POS_W  = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              valid,
  output logic              result,
  output logic [POS_W-1:0]  fail_pos
);

  localparam int DEPTH = 2**DATA_W - 1;
  localparam logic [DATA_W-1:0] ONE = 1;
  localparam logic [DATA_W:0] NX_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PUSH,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] n_reg;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W:0]   next_in;
  logic [DATA_W-1:0] d_reg;
  logic              fail;
  logic [POS_W-1:0]  fpos;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] stack [DEPTH];

  logic              consume;
  logic [DATA_W:0]   dx;
  logic [DATA_W-1:0] cnt_inc;
  logic [DATA_W-1:0] top_idx;
  logic [POS_W-1:0]  pos_now;
  logic              over;
  logic              hit;
  logic              ahead;
  logic              top_ok;
  logic              push_last;
  logic              fail_now;
  logic              advance;
  logic              go_push;
  logic              do_pop;
  logic              fail_n;

  assign consume   = ready && (data != '0);
  assign dx        = {1'b0, data};
  assign cnt_inc   = cnt + ONE;
  assign top_idx   = sp - ONE;
  assign pos_now   = POS_W'(cnt_inc);
  assign over      = data > n_reg;
  assign hit       = dx == next_in;
  assign ahead     = dx > next_in;
  assign top_ok    = (sp != '0) && (stack[top_idx] == data);
  assign push_last = next_in == ({1'b0, d_reg} - NX_ONE);
  assign fail_n    = fail || fail_now;

  always_comb begin
    state_n  = state;
    fail_now = 1'b0;
    advance  = 1'b0;
    go_push  = 1'b0;
    do_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (consume) state_n = RECV;
      end
      RECV: begin
        if (consume) begin
          // once failed, words are only counted so frame timing is unchanged
          if (!fail) begin
            if (over)        fail_now = 1'b1;
            else if (hit)    advance  = 1'b1;
            else if (ahead)  go_push  = 1'b1;
            else if (top_ok) do_pop   = 1'b1;
            else             fail_now = 1'b1;
          end
          if (go_push)               state_n = PUSH;
          else if (cnt_inc == n_reg) state_n = DONE;
        end
      end
      PUSH: begin
        if (push_last) state_n = (cnt == n_reg) ? DONE : RECV;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      result   <= 1'b0;
      fail_pos <= '0;
      n_reg    <= '0;
      cnt      <= '0;
      next_in  <= NX_ONE;
      d_reg    <= '0;
      fail     <= 1'b0;
      fpos     <= '0;
      sp       <= '0;
    end else begin
      state <= state_n;
      ready <= (state_n == IDLE) || (state_n == RECV);
      valid <= state_n == DONE;
      if (state_n == DONE) begin
        result <= !fail_n;
        if (fail)          fail_pos <= fpos;
        else if (fail_now) fail_pos <= pos_now;
        else               fail_pos <= '0;
      end
      unique case (state)
        IDLE: begin
          if (consume) begin
            n_reg   <= data;
            cnt     <= '0;
            next_in <= NX_ONE;
            sp      <= '0;
            fail    <= 1'b0;
            fpos    <= '0;
          end
        end
        RECV: begin
          if (consume) begin
            cnt <= cnt_inc;
            if (fail_now) begin
              fail <= 1'b1;
              fpos <= pos_now;
            end
            if (advance) next_in <= dx + NX_ONE;
            if (go_push) d_reg <= data;
            if (do_pop)  sp <= sp - ONE;
          end
        end
        PUSH: begin
          sp <= sp + ONE;
          // the departing train itself skips the stack
          if (push_last) next_in <= {1'b0, d_reg} + NX_ONE;
          else           next_in <= next_in + NX_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == PUSH) begin
      stack[sp] <= next_in[DATA_W-1:0];
    end
  end

endmodule
